cpu_dbus_bridge: RTL and testbench
==================================

// Module: cpu_dbus_bridge
// PURPOSE
//  Data-side bus bridge directly downstream of the CPU execute/memory stage. Captures the
//  single-cycle cpu_request (address/write/wstrb/wdata) and drives it onto the system bus
//  with a request/ready handshake. Returns read data, or a write acknowledge, as a cpu_valid
//  pulse that releases the pipeline stall. A watchdog terminates hung transactions with an
//  error. One transaction is outstanding at a time.
// PARAMETERS
//  POSTED_WRITES  1           1: a write completes when the bus accepts it; 0: it waits for bus_rvalid
//  TIMEOUT        1024        cycles in REQ+WAIT before forced completion (>=2)
//  ERR_DATA       32'hDEADBEEF cpu_rdata returned on a timed-out transaction
// PORTS
//  clock         in   1   system clock
//  reset         in   1   asynchronous, active-high reset
//  cpu_request   in   1   CPU issues an access this cycle (single-cycle pulse)
//  cpu_address   in   32  byte address, valid with cpu_request
//  cpu_write     in   1   1=store, 0=load
//  cpu_wstrb     in   4   byte enables for a store
//  cpu_wdata     in   32  store data, lanes selected by cpu_wstrb
//  cpu_rdata     out  32  load data, valid while cpu_valid=1
//  cpu_valid     out  1   transaction complete (loads and stores)
//  cpu_mem_busy  out  1   a transaction is outstanding (state != IDLE)
//  bus_request   out  1   request to system bus, held until bus_ready
//  bus_address   out  32  registered address
//  bus_write     out  1   registered direction
//  bus_wstrb     out  4   registered byte enables (4'b0000 on loads)
//  bus_wdata     out  32  registered store data
//  bus_ready     in   1   bus accepts the request this cycle
//  bus_rvalid    in   1   read data / write ack from the bus
//  bus_rdata     in   32  read data
//  bus_error     out  1   one-cycle pulse on timeout or protocol violation
// BEHAVIOUR
//  - Reset (async): state=IDLE, timer=0, bus_request=0, bus_error=0, and all bus_* data
//    registers=0. cpu_valid=0 and cpu_mem_busy=0 immediately. Reset mid-transaction abandons it.
//  - States: IDLE -> REQ -> WAIT -> IDLE.
//    IDLE: cpu_request=1 latches the address/write/wstrb/wdata registers and moves to REQ.
//          bus_request rises on the next cycle (latency 1).
//    REQ:  bus_request=1. On bus_ready: a write with POSTED_WRITES=1 asserts cpu_valid in
//          that same cycle and goes to IDLE; otherwise go to WAIT. bus_request drops the
//          cycle after bus_ready.
//    WAIT: cpu_valid = bus_rvalid and cpu_rdata = bus_rdata (combinational pass-through).
//          On bus_rvalid go to IDLE.
//  - Back-to-back: a cpu_request in the same cycle cpu_valid=1 is accepted. It latches and
//    goes straight to REQ, so there is no idle bubble.
//  - A cpu_request while busy and not completing is a protocol violation. It is dropped,
//    bus_error pulses, and the current transaction continues unaffected.
//  - Timer: cleared on entry to REQ and incremented each cycle in REQ/WAIT. At
//    timer==TIMEOUT-1 with no completion this cycle, the bridge forces completion:
//    cpu_valid=1, cpu_rdata=ERR_DATA, bus_error=1, go to IDLE, and bus_request drops next
//    cycle. A real completion in that same cycle takes priority and raises no error.
//  - bus_rvalid seen in IDLE or REQ (e.g. a late response after timeout) is ignored and
//    never produces cpu_valid.
//  - cpu_rdata=32'h0 whenever cpu_valid=0. cpu_valid is never asserted for more than one
//    cycle per transaction.
// TESTING
//  1. Load: req addr=0x100 -> bus_request at N+1; ready at N+1, rvalid+rdata=0x12345678 at
//     N+3 -> cpu_valid=1 with cpu_rdata=0x12345678 at N+3, then IDLE.
//  2. Posted store: addr=0x204 wstrb=4'b1100 wdata=0xAABB0000, ready at N+2 -> cpu_valid at
//     N+2; bus_wstrb=4'b1100; no rvalid required.
//  3. Back-to-back: second cpu_request in the cpu_valid cycle of a load -> bus_request
//     re-asserts the next cycle with the new address, no idle cycle.
//  4. Timeout (TIMEOUT=8): bus_ready held 0 -> cpu_valid=1, cpu_rdata=0xDEADBEEF and
//     bus_error=1 on the 8th cycle of REQ; a later stray bus_rvalid is ignored.
//  5. Protocol: cpu_request while in WAIT -> bus_error pulse; the original load still
//     returns its data correctly.
//  6. Async reset asserted in WAIT -> cpu_mem_busy=0 and bus_request=0 without a clock edge;
//     the next request proceeds normally.

Source files
------------

// File: rtl/cpu_dbus_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_dbus_bridge: CPU data-side request/ready bus bridge with watchdog    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpu_dbus_bridge #(
  parameter int          POSTED_WRITES = 1,
  parameter int          TIMEOUT       = 1024,
  parameter logic [31:0] ERR_DATA      = 32'hDEADBEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_request,
  input  logic [31:0] cpu_address,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_valid,
  output logic        cpu_mem_busy,
  output logic        bus_request,
  output logic [31:0] bus_address,
  output logic        bus_write,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        bus_error
);

  localparam int                 TIMER_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [31:0]        addr_q, addr_d;
  logic               write_q, write_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [31:0]        wdata_q, wdata_d;

  logic busy;
  logic real_done;
  logic timeout_fire;
  logic completing;
  logic accept;
  logic violation;

  always_comb begin
    real_done = 1'b0;
    case (state_q)
      REQ:     real_done = bus_ready && write_q && (POSTED_WRITES != 0);
      WAIT:    real_done = bus_rvalid;
      default: real_done = 1'b0;
    endcase

    busy         = (state_q != IDLE);
    // A genuine completion on the last watchdog cycle wins over the timeout.
    timeout_fire = busy && !real_done && (timer_q == TIMER_LAST);
    completing   = real_done || timeout_fire;
    accept       = cpu_request && (!busy || completing);
    violation    = cpu_request && busy && !completing;

    state_d = state_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    write_d = write_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;

    if (accept) begin
      state_d = REQ;
      timer_d = '0;
      addr_d  = cpu_address;
      write_d = cpu_write;
      wstrb_d = cpu_write ? cpu_wstrb : 4'b0000;
      wdata_d = cpu_wdata;
    end else if (completing) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        REQ: begin
          if (bus_ready) state_d = WAIT;
          timer_d = timer_q + TIMER_W'(1);
        end
        WAIT:    timer_d = timer_q + TIMER_W'(1);
        IDLE:    timer_d = '0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wstrb_q <= 4'b0000;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
    end
  end

  // Response data is only ever taken from the bus while a read is awaited.
  always_comb begin
    cpu_rdata = 32'h0;
    if (timeout_fire)
      cpu_rdata = ERR_DATA;
    else if ((state_q == WAIT) && bus_rvalid)
      cpu_rdata = bus_rdata;
  end

  assign cpu_valid    = completing;
  assign cpu_mem_busy = busy;
  assign bus_request  = (state_q == REQ);
  assign bus_address  = addr_q;
  assign bus_write    = write_q;
  assign bus_wstrb    = wstrb_q;
  assign bus_wdata    = wdata_q;
  assign bus_error    = timeout_fire || violation;

endmodule
`default_nettype wire

// File: tb/tb_cpu_dbus_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_dbus_bridge: scoreboard bench for cpu_dbus_bridge                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cpu_dbus_bridge;

  localparam int          TIMEOUT  = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
  localparam int          NEVER    = 99;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_request = 1'b0;
  logic [31:0] cpu_address = '0;
  logic        cpu_write = 1'b0;
  logic [3:0]  cpu_wstrb = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_valid;
  logic        cpu_mem_busy;
  logic        bus_request;
  logic [31:0] bus_address;
  logic        bus_write;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_error;

  cpu_dbus_bridge #(
    .POSTED_WRITES(1),
    .TIMEOUT      (TIMEOUT),
    .ERR_DATA     (ERR_DATA)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_request (cpu_request),
    .cpu_address (cpu_address),
    .cpu_write   (cpu_write),
    .cpu_wstrb   (cpu_wstrb),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_valid   (cpu_valid),
    .cpu_mem_busy(cpu_mem_busy),
    .bus_request (bus_request),
    .bus_address (bus_address),
    .bus_write   (bus_write),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_ready   (bus_ready),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .bus_error   (bus_error)
  );

  always #5 clock = ~clock;

  // r: REQ cycle (1-based) in which the bus accepts; w: cycles later rvalid arrives
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          r;
    int          w;
    logic [31:0] rdata;
    int          viol;
    logic        b2b;
  } txn_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        chk_data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   viol_q[$];
  txn_t list[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles from request to completion, clipped by the watchdog.
  function automatic int span(input txn_t t);
    int k;
    k = t.wr ? t.r : t.r + t.w;
    return (k > TIMEOUT) ? TIMEOUT : k;
  endfunction

  function automatic exp_t model(input txn_t t, input int issue_cyc);
    exp_t e;
    int   k;
    k = t.wr ? t.r : t.r + t.w;
    e.cyc = issue_cyc + span(t);
    if (k > TIMEOUT) begin
      e.rdata = ERR_DATA; e.chk_data = 1'b1; e.err = 1'b1;
    end else begin
      e.rdata = t.rdata; e.chk_data = !t.wr; e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic clear_inputs();
    cpu_request = 1'b0;
    bus_ready   = 1'b0;
    bus_rvalid  = 1'b0;
    bus_rdata   = '0;
  endtask

  task automatic issue(input txn_t t);
    cpu_request = 1'b1;
    cpu_address = t.addr;
    cpu_write   = t.wr;
    cpu_wstrb   = t.strb;
    cpu_wdata   = t.wdata;
    exp_q.push_back(model(t, cyc));
  endtask

  task automatic serve(input txn_t t, input logic b2b, input txn_t nxt);
    int ke;
    ke = span(t);
    for (int c = 1; c <= ke; c++) begin
      @(posedge clock); #1;
      clear_inputs();
      if (c == 1) begin
        check("bus_request_rise", {31'b0, bus_request}, 32'd1);
        check("busy_in_req", {31'b0, cpu_mem_busy}, 32'd1);
        check("bus_address", bus_address, t.addr);
        check("bus_write", {31'b0, bus_write}, {31'b0, t.wr});
        check("bus_wstrb", {28'b0, bus_wstrb}, t.wr ? {28'b0, t.strb} : 32'd0);
        if (t.wr) check("bus_wdata", bus_wdata, t.wdata);
      end
      if (c <= t.r && $urandom_range(3) == 0) begin
        bus_rvalid = 1'b1;
        bus_rdata  = $urandom;
      end
      if (c == t.r) bus_ready = 1'b1;
      if (!t.wr && c == t.r + t.w) begin
        bus_rvalid = 1'b1;
        bus_rdata  = t.rdata;
      end
      if (c == t.viol) begin
        cpu_request = 1'b1;
        cpu_address = $urandom;
        cpu_write   = 1'($urandom_range(1));
        viol_q.push_back(cyc);
      end
      if (c == ke && b2b) issue(nxt);
    end
  endtask

  task automatic idle(input int n, input logic stray);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      clear_inputs();
      if (i == 0) begin
        check("idle_busy", {31'b0, cpu_mem_busy}, 32'd0);
        check("idle_bus_request", {31'b0, bus_request}, 32'd0);
      end
      if (stray && ($urandom_range(1) == 1 || i == 0)) begin
        bus_rvalid = 1'b1;
        bus_rdata  = $urandom;
      end
    end
  endtask

  task automatic run_list();
    for (int i = 0; i < list.size(); i++) begin
      logic b2b;
      b2b = list[i].b2b && (i + 1 < list.size());
      if (i == 0 || !list[i-1].b2b) begin
        @(posedge clock); #1;
        clear_inputs();
        issue(list[i]);
      end
      serve(list[i], b2b, (i + 1 < list.size()) ? list[i+1] : list[i]);
      if (!b2b) idle(1 + $urandom_range(2), 1'($urandom_range(1)) || list[i].r == NEVER);
    end
    list.delete();
  endtask

  function automatic txn_t mk(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] wdata, input int r, input int w,
                              input logic [31:0] rdata, input int viol, input logic b2b);
    txn_t t;
    t.wr = wr; t.addr = addr; t.strb = strb; t.wdata = wdata; t.r = r; t.w = w;
    t.rdata = rdata; t.viol = viol; t.b2b = b2b;
    return t;
  endfunction

  // Scoreboard: every cpu_valid must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && mon_en) begin
      if (cpu_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got cpu_valid=1, expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("valid_cycle", cyc, e.cyc);
          if (e.chk_data) check("cpu_rdata", cpu_rdata, e.rdata);
          check("err_on_valid", {31'b0, bus_error}, {31'b0, e.err});
        end
      end else begin
        check("rdata_zero_idle", cpu_rdata, 32'h0);
        if (bus_error) begin
          if (viol_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_error: got bus_error=1, expected 0 (cycle %0d)", cyc);
          end else begin
            check("violation_cycle", cyc, viol_q.pop_front());
          end
        end else if (viol_q.size() != 0 && viol_q[0] < cyc) begin
          checks++; errors++;
          $display("FAIL missing_violation: got no bus_error, expected one at cycle %0d", viol_q[0]);
          void'(viol_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got no finish, expected end before 100000ns");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2;
    check("rst_valid", {31'b0, cpu_valid}, 32'd0);
    check("rst_busy", {31'b0, cpu_mem_busy}, 32'd0);
    check("rst_bus_request", {31'b0, bus_request}, 32'd0);
    check("rst_bus_error", {31'b0, bus_error}, 32'd0);
    check("rst_bus_address", bus_address, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    list.push_back(mk(1'b0, 32'h100, 4'h0, 32'h0, 1, 2, 32'h12345678, 0, 1'b0));
    list.push_back(mk(1'b1, 32'h204, 4'b1100, 32'hAABB0000, 2, 1, 32'h0, 0, 1'b0));
    list.push_back(mk(1'b0, 32'h300, 4'h0, 32'h0, 1, 1, 32'h0BADF00D, 0, 1'b1));
    list.push_back(mk(1'b0, 32'h304, 4'h0, 32'h0, 2, 1, 32'h13572468, 0, 1'b0));
    list.push_back(mk(1'b0, 32'h400, 4'h0, 32'h0, NEVER, 1, 32'h0, 0, 1'b0));
    list.push_back(mk(1'b0, 32'h500, 4'h0, 32'h0, 1, 4, 32'hCAFEF00D, 3, 1'b0));
    list.push_back(mk(1'b1, 32'h508, 4'b0011, 32'h00001234, TIMEOUT, 1, 32'h0, 2, 1'b0));
    list.push_back(mk(1'b0, 32'h50C, 4'h0, 32'h0, TIMEOUT - 1, 1, 32'h55AA55AA, 0, 1'b0));
    run_list();

    // Abandon a load in WAIT with an asynchronous reset between clock edges.
    @(posedge clock); #1;
    clear_inputs();
    cpu_request = 1'b1; cpu_address = 32'h600; cpu_write = 1'b0;
    @(posedge clock); #1;
    clear_inputs();
    bus_ready = 1'b1;
    @(posedge clock); #1;
    clear_inputs();
    #2 reset = 1'b1;
    #1;
    check("async_busy", {31'b0, cpu_mem_busy}, 32'd0);
    check("async_bus_request", {31'b0, bus_request}, 32'd0);
    check("async_valid", {31'b0, cpu_valid}, 32'd0);
    check("async_bus_address", bus_address, 32'h0);
    @(posedge clock); #1 reset = 1'b0;

    list.push_back(mk(1'b0, 32'h700, 4'h0, 32'h0, 1, 1, 32'h76543210, 0, 1'b0));
    for (int i = 0; i < 40; i++) begin
      txn_t t;
      int   ke;
      t.wr    = 1'($urandom_range(1));
      t.addr  = $urandom & 32'hFFFF_FFFC;
      t.strb  = 4'($urandom);
      t.wdata = $urandom;
      t.r     = ($urandom_range(9) == 0) ? NEVER : int'($urandom_range(1, TIMEOUT + 1));
      t.w     = int'($urandom_range(1, 4));
      t.rdata = $urandom;
      t.b2b   = 1'($urandom_range(1));
      t.viol  = 0;
      ke = span(t);
      if (ke > 1 && $urandom_range(2) == 0) t.viol = int'($urandom_range(1, ke - 1));
      list.push_back(t);
    end
    run_list();

    idle(3, 1'b1);
    check("exp_queue_drained", exp_q.size(), 32'd0);
    check("viol_queue_drained", viol_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
